// File: rtl/fb_sdram_arbiter.sv
// Read-priority arbiter sharing one sdram_controller host port between scanout reads
// and a posted render write FIFO. Define FB_ARB_STATS_EN to add grant/stall counters.
module fb_sdram_arbiter #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WFIFO_DEPTH = 8,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_req_valid,
  output logic                         wr_req_ready,
  input  logic [ADDR_W-1:0]            wr_req_addr,
  input  logic [DATA_W-1:0]            wr_req_data,
  input  logic                         rd_req_valid,
  output logic                         rd_req_ready,
  input  logic [ADDR_W-1:0]            rd_req_addr,
  output logic                         rd_resp_valid,
  output logic [DATA_W-1:0]            rd_resp_data,
  output logic [ADDR_W-1:0]            ctrl_wr_addr,
  output logic [DATA_W-1:0]            ctrl_wr_data,
  output logic                         ctrl_wr_enable,
  output logic [ADDR_W-1:0]            ctrl_rd_addr,
  output logic                         ctrl_rd_enable,
  input  logic [DATA_W-1:0]            ctrl_rd_data,
  input  logic                         ctrl_rd_ready,
  input  logic                         ctrl_busy,
`ifdef FB_ARB_STATS_EN
  output logic [31:0]                  stat_wr_count,
  output logic [31:0]                  stat_rd_count,
  output logic [31:0]                  stat_full_stall,
`endif
  output logic [$clog2(WFIFO_DEPTH):0] wfifo_level
);

  localparam int unsigned PW = $clog2(WFIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_LVL   = CW'(WFIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_RD_ISSUE,
    ST_WR_WAIT,
    ST_RD_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q [WFIFO_DEPTH];
  logic [ADDR_W-1:0] mem_addr_d [WFIFO_DEPTH];
  logic [DATA_W-1:0] mem_data_q [WFIFO_DEPTH];
  logic [DATA_W-1:0] mem_data_d [WFIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              seen_busy_q, seen_busy_d;
  logic              wait_late_q, wait_late_d;
  logic              captured_q, captured_d;
  logic [ADDR_W-1:0] ctrl_wr_addr_q, ctrl_wr_addr_d, ctrl_rd_addr_q, ctrl_rd_addr_d;
  logic [DATA_W-1:0] ctrl_wr_data_q, ctrl_wr_data_d;
  logic              ctrl_wr_en_q, ctrl_wr_en_d, ctrl_rd_en_q, ctrl_rd_en_d;
  logic              rd_resp_valid_q, rd_resp_valid_d;
  logic [DATA_W-1:0] rd_resp_data_q, rd_resp_data_d;

  logic full, empty, push, arb_ok, rd_grant, wr_grant;

  assign full         = (count_q == FULL_LVL);
  assign empty        = (count_q == '0);
  assign wr_req_ready = !rst && !full;
  assign push         = wr_req_valid && wr_req_ready;
  assign arb_ok       = !rst && (state_q == ST_IDLE) && !ctrl_busy;
  // A full FIFO overrides read priority so the render side can make progress.
  assign rd_grant     = arb_ok && !full && rd_req_valid && (empty || (starve_q < STARVE_LIM));
  assign wr_grant     = arb_ok && !empty && !rd_grant;

  assign rd_req_ready   = rd_grant;
  assign rd_resp_valid  = rd_resp_valid_q;
  assign rd_resp_data   = rd_resp_data_q;
  assign ctrl_wr_addr   = ctrl_wr_addr_q;
  assign ctrl_wr_data   = ctrl_wr_data_q;
  assign ctrl_wr_enable = ctrl_wr_en_q;
  assign ctrl_rd_addr   = ctrl_rd_addr_q;
  assign ctrl_rd_enable = ctrl_rd_en_q;
  assign wfifo_level    = count_q;

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_addr_d[wr_ptr_q] = wr_req_addr;
      mem_data_d[wr_ptr_q] = wr_req_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (wr_grant) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, wr_grant})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    starve_d        = starve_q;
    seen_busy_d     = seen_busy_q;
    wait_late_d     = wait_late_q;
    captured_d      = captured_q;
    ctrl_wr_addr_d  = ctrl_wr_addr_q;
    ctrl_wr_data_d  = ctrl_wr_data_q;
    ctrl_rd_addr_d  = ctrl_rd_addr_q;
    ctrl_wr_en_d    = 1'b0;
    ctrl_rd_en_d    = 1'b0;
    rd_resp_valid_d = 1'b0;
    rd_resp_data_d  = rd_resp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_grant) begin
          ctrl_rd_addr_d = rd_req_addr;
          ctrl_rd_en_d   = 1'b1;
          if (!empty && (starve_q != STARVE_LIM)) starve_d = starve_q + SW'(1);
          state_d = ST_RD_ISSUE;
        end else if (wr_grant) begin
          ctrl_wr_addr_d = mem_addr_q[rd_ptr_q];
          ctrl_wr_data_d = mem_data_q[rd_ptr_q];
          ctrl_wr_en_d   = 1'b1;
          starve_d       = '0;
          state_d        = ST_WR_ISSUE;
        end
      end
      ST_WR_ISSUE: begin
        seen_busy_d = 1'b0;
        wait_late_d = 1'b0;
        state_d     = ST_WR_WAIT;
      end
      ST_RD_ISSUE: begin
        captured_d = 1'b0;
        state_d    = ST_RD_WAIT;
      end
      ST_WR_WAIT: begin
        // Without a busy phase, give up after the second wait cycle.
        seen_busy_d = seen_busy_q | ctrl_busy;
        wait_late_d = 1'b1;
        if (seen_busy_q ? !ctrl_busy : (!ctrl_busy && wait_late_q)) state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (captured_q) begin
          if (!ctrl_busy) state_d = ST_IDLE;
        end else if (ctrl_rd_ready) begin
          rd_resp_data_d  = ctrl_rd_data;
          rd_resp_valid_d = 1'b1;
          captured_d      = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      starve_q        <= '0;
      seen_busy_q     <= 1'b0;
      wait_late_q     <= 1'b0;
      captured_q      <= 1'b0;
      ctrl_wr_addr_q  <= '0;
      ctrl_wr_data_q  <= '0;
      ctrl_rd_addr_q  <= '0;
      ctrl_wr_en_q    <= 1'b0;
      ctrl_rd_en_q    <= 1'b0;
      rd_resp_valid_q <= 1'b0;
      rd_resp_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      starve_q        <= starve_d;
      seen_busy_q     <= seen_busy_d;
      wait_late_q     <= wait_late_d;
      captured_q      <= captured_d;
      ctrl_wr_addr_q  <= ctrl_wr_addr_d;
      ctrl_wr_data_q  <= ctrl_wr_data_d;
      ctrl_rd_addr_q  <= ctrl_rd_addr_d;
      ctrl_wr_en_q    <= ctrl_wr_en_d;
      ctrl_rd_en_q    <= ctrl_rd_en_d;
      rd_resp_valid_q <= rd_resp_valid_d;
      rd_resp_data_q  <= rd_resp_data_d;
    end
  end

`ifdef FB_ARB_STATS_EN
  logic [31:0] stat_wr_q, stat_wr_d, stat_rd_q, stat_rd_d, stat_stall_q, stat_stall_d;

  always_comb begin
    stat_wr_d    = stat_wr_q;
    stat_rd_d    = stat_rd_q;
    stat_stall_d = stat_stall_q;
    if (wr_grant) stat_wr_d = stat_wr_q + 32'd1;
    if (rd_grant) stat_rd_d = stat_rd_q + 32'd1;
    if (wr_req_valid && !wr_req_ready) stat_stall_d = stat_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_q    <= '0;
      stat_rd_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_wr_q    <= stat_wr_d;
      stat_rd_q    <= stat_rd_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_wr_count   = stat_wr_q;
  assign stat_rd_count   = stat_rd_q;
  assign stat_full_stall = stat_stall_q;
`endif

endmodule
